// File: rtl/control_unit_pkg.sv
// Shared LEGv8 decode constants, control-word layout and FSM encoding
// used by control_unit and its immediate generator.
package control_unit_pkg;

  localparam int unsigned CW_WIDTH    = 23;
  localparam int unsigned CW_DA_LSB   = 18;
  localparam int unsigned CW_SA_LSB   = 13;
  localparam int unsigned CW_SB_LSB   = 8;
  localparam int unsigned CW_FS_LSB   = 4;
  localparam int unsigned CW_BSEL     = 3;
  localparam int unsigned CW_REGWRITE = 2;
  localparam int unsigned CW_MEMWRITE = 1;
  localparam int unsigned CW_MEMTOREG = 0;

  localparam logic [4:0] REG_XZR = 5'd31;

  // Opcodes, aligned to the top bits of the instruction word.
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [3:0] FS_AND = 4'b0000;
  localparam logic [3:0] FS_ORR = 4'b0001;
  localparam logic [3:0] FS_ADD = 4'b0010;
  localparam logic [3:0] FS_SUB = 4'b0110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_BRCHK
  } state_t;

  typedef enum logic [2:0] {
    CLS_ILLEGAL,
    CLS_R,
    CLS_I,
    CLS_LDUR,
    CLS_STUR,
    CLS_CBZ,
    CLS_B
  } instr_class_t;

  // opc is instr[31:21]; shorter opcodes compare against its upper bits.
  function automatic instr_class_t classify(input logic [10:0] opc);
    instr_class_t cls;
    cls = CLS_ILLEGAL;
    if (opc == OP_ADD || opc == OP_SUB || opc == OP_AND || opc == OP_ORR)
      cls = CLS_R;
    else if (opc[10:1] == OP_ADDI || opc[10:1] == OP_SUBI)
      cls = CLS_I;
    else if (opc == OP_LDUR)
      cls = CLS_LDUR;
    else if (opc == OP_STUR)
      cls = CLS_STUR;
    else if (opc[10:3] == OP_CBZ)
      cls = CLS_CBZ;
    else if (opc[10:5] == OP_B)
      cls = CLS_B;
    return cls;
  endfunction

  function automatic logic [3:0] alu_fs(input logic [10:0] opc);
    logic [3:0] fs;
    fs = FS_ADD;
    if (opc == OP_SUB || opc[10:1] == OP_SUBI)
      fs = FS_SUB;
    else if (opc == OP_AND)
      fs = FS_AND;
    else if (opc == OP_ORR)
      fs = FS_ORR;
    return fs;
  endfunction

endpackage

// File: rtl/control_unit_imm_gen.sv
// Combinational immediate / branch-offset generator driven by the latched
// instruction and its decoded class.
module control_unit_imm_gen
  import control_unit_pkg::*;
(
  input  logic [25:0]  imm_field,
  input  instr_class_t cls,
  output logic [63:0]  k
);

  always_comb begin
    k = '0;
    unique case (cls)
      CLS_I:              k = {52'd0, imm_field[21:10]};
      CLS_LDUR, CLS_STUR: k = {{55{imm_field[20]}}, imm_field[20:12]};
      CLS_CBZ:            k = {{43{imm_field[23]}}, imm_field[23:5], 2'b00};
      CLS_B:              k = {{36{imm_field[25]}}, imm_field[25:0], 2'b00};
      default:            k = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle LEGv8 control unit: accepts one instruction at a time, steps
// it through DECODE/EXEC/MEM/WB/BRCHK and emits control word and PC pulses.
module control_unit
  import control_unit_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [3:0]          status,
  output logic [CW_WIDTH-1:0] control_word,
  output logic [63:0]         k,
  output logic                pc_inc,
  output logic                pc_branch,
  output logic                done,
  output logic                illegal
);

  state_t       state, state_next;
  logic [31:0]  instr_q;
  instr_class_t cls;
  logic [63:0]  k_raw;
  logic         accept;
  logic         zero_flag;
  logic         status_unused;
  logic [4:0]   rd, rn, rm;

  assign instr_ready   = (state == ST_IDLE) && reset;
  assign accept        = instr_valid && instr_ready;
  assign cls           = classify(instr_q[31:21]);
  assign zero_flag     = status[0];
  assign status_unused = ^status[3:1];
  assign rd            = instr_q[4:0];
  assign rn            = instr_q[9:5];
  assign rm            = instr_q[20:16];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Only written on accept, so traffic while busy cannot disturb it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= '0;
    end else if (accept) begin
      instr_q <= instr;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (accept) state_next = ST_DECODE;
      ST_DECODE: state_next = (cls == CLS_ILLEGAL) ? ST_IDLE : ST_EXEC;
      ST_EXEC: begin
        unique case (cls)
          CLS_R, CLS_I:       state_next = ST_WB;
          CLS_LDUR, CLS_STUR: state_next = ST_MEM;
          CLS_CBZ:            state_next = ST_BRCHK;
          default:            state_next = ST_IDLE;
        endcase
      end
      ST_MEM:    state_next = (cls == CLS_STUR) ? ST_IDLE : ST_WB;
      ST_WB:     state_next = ST_IDLE;
      ST_BRCHK:  state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    control_word = '0;
    pc_inc       = 1'b0;
    pc_branch    = 1'b0;
    done         = 1'b0;
    illegal      = 1'b0;

    // Register/ALU fields are a function of the latched instruction only,
    // so they stay stable for every non-idle cycle of that instruction.
    if (state != ST_IDLE) begin
      unique case (cls)
        CLS_R: begin
          control_word[CW_DA_LSB +: 5] = rd;
          control_word[CW_SA_LSB +: 5] = rn;
          control_word[CW_SB_LSB +: 5] = rm;
          control_word[CW_FS_LSB +: 4] = alu_fs(instr_q[31:21]);
        end
        CLS_I: begin
          control_word[CW_DA_LSB +: 5] = rd;
          control_word[CW_SA_LSB +: 5] = rn;
          control_word[CW_FS_LSB +: 4] = alu_fs(instr_q[31:21]);
          control_word[CW_BSEL]        = 1'b1;
        end
        CLS_LDUR: begin
          control_word[CW_DA_LSB +: 5] = rd;
          control_word[CW_SA_LSB +: 5] = rn;
          control_word[CW_FS_LSB +: 4] = FS_ADD;
          control_word[CW_BSEL]        = 1'b1;
        end
        CLS_STUR: begin
          control_word[CW_SA_LSB +: 5] = rn;
          control_word[CW_SB_LSB +: 5] = rd;
          control_word[CW_FS_LSB +: 4] = FS_ADD;
          control_word[CW_BSEL]        = 1'b1;
        end
        CLS_CBZ: begin
          control_word[CW_SA_LSB +: 5] = rd;
          control_word[CW_SB_LSB +: 5] = REG_XZR;
          control_word[CW_FS_LSB +: 4] = FS_ADD;
        end
        default: ;
      endcase
    end

    unique case (state)
      ST_DECODE: illegal = (cls == CLS_ILLEGAL);
      ST_EXEC: begin
        if (cls == CLS_B) begin
          pc_branch = 1'b1;
          done      = 1'b1;
        end
      end
      ST_MEM: begin
        if (cls == CLS_STUR) begin
          control_word[CW_MEMWRITE] = 1'b1;
          pc_inc                    = 1'b1;
          done                      = 1'b1;
        end
      end
      ST_WB: begin
        control_word[CW_REGWRITE] = 1'b1;
        control_word[CW_MEMTOREG] = (cls == CLS_LDUR);
        pc_inc                    = 1'b1;
        done                      = 1'b1;
      end
      ST_BRCHK: begin
        pc_branch = zero_flag;
        pc_inc    = !zero_flag;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

  control_unit_imm_gen u_imm_gen (
    .imm_field (instr_q[25:0]),
    .cls       (cls),
    .k         (k_raw)
  );

  assign k = (state == ST_IDLE) ? '0 : k_raw;

endmodule
